// File: rtl/isp1761_bus_sequencer.sv
// isp1761_bus_sequencer: arbitrates the HC and DC Avalon slaves onto the single ISP1761
// parallel bus and generates registered CS_N/RD_N/WR_N strobes with programmable timing.
module isp1761_bus_sequencer #(
    parameter int T_SETUP   = 1,
    parameter int T_STROBE  = 2,
    parameter int T_HOLD    = 1,
    parameter int T_RECOVER = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hc_read,
    input  logic        hc_write,
    input  logic [17:0] hc_address,
    input  logic [31:0] hc_writedata,
    output logic [31:0] hc_readdata,
    output logic        hc_waitrequest,
    input  logic        dc_read,
    input  logic        dc_write,
    input  logic [17:0] dc_address,
    input  logic [31:0] dc_writedata,
    output logic [31:0] dc_readdata,
    output logic        dc_waitrequest,
    output logic        bus_cs_n,
    output logic        bus_rd_n,
    output logic        bus_wr_n,
    output logic [16:0] bus_a,
    output logic [31:0] bus_dout,
    output logic        bus_doe,
    input  logic [31:0] bus_din
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;
    // Counter reload values; a zero-length phase is skipped, so its reload is never used.
    localparam logic [3:0] L_SETUP  = 4'(T_SETUP - 1);
    localparam logic [3:0] L_STROBE = 4'(T_STROBE - 1);
    localparam logic [3:0] L_HOLD   = 4'(T_HOLD - 1);
    localparam logic [3:0] L_REC    = 4'(T_RECOVER - 1);
    localparam state_t POST = (T_RECOVER > 0) ? RECOVER : IDLE;

    state_t     state, nxt_state;
    logic [3:0] cnt, nxt_cnt;
    logic       gnt_dc, wr, last_dc, ack_hc, ack_dc;
    logic       hc_elig, dc_elig, pick_dc, go, sel_wr, nxt_wr;
    logic       last_strobe, done, on_bus;
    logic       unused_addr_lsb;

    assign unused_addr_lsb = hc_address[0] ^ dc_address[0];
    assign hc_waitrequest  = (hc_read | hc_write) & ~ack_hc;
    assign dc_waitrequest  = (dc_read | dc_write) & ~dc_ack_mask();

    function automatic logic dc_ack_mask();
        return ack_dc;
    endfunction

    always_comb begin
        hc_elig     = (hc_read | hc_write) & ~ack_hc;
        dc_elig     = (dc_read | dc_write) & ~ack_dc;
        pick_dc     = dc_elig & (~hc_elig | ~last_dc);
        go          = (state == IDLE) & (hc_elig | dc_elig);
        sel_wr      = pick_dc ? dc_write : hc_write;
        nxt_wr      = go ? sel_wr : wr;
        last_strobe = (state == STROBE) & (cnt == 4'd0);
        done        = (last_strobe & (T_HOLD == 0)) | ((state == HOLD) & (cnt == 4'd0));
        nxt_state   = state;
        nxt_cnt     = cnt - 4'd1;
        case (state)
            IDLE: begin
                nxt_state = go ? SETUP : IDLE;
                nxt_cnt   = L_SETUP;
            end
            SETUP: if (cnt == 4'd0) begin
                nxt_state = STROBE;
                nxt_cnt   = L_STROBE;
            end
            STROBE: if (cnt == 4'd0) begin
                nxt_state = (T_HOLD > 0) ? HOLD : POST;
                nxt_cnt   = (T_HOLD > 0) ? L_HOLD : L_REC;
            end
            HOLD: if (cnt == 4'd0) begin
                nxt_state = POST;
                nxt_cnt   = L_REC;
            end
            RECOVER: if (cnt == 4'd0) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        on_bus = (nxt_state == SETUP) | (nxt_state == STROBE) | (nxt_state == HOLD);
    end

    // Pins are driven from the next state so every output is a plain flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            gnt_dc      <= 1'b0;
            wr          <= 1'b0;
            last_dc     <= 1'b1;
            ack_hc      <= 1'b0;
            ack_dc      <= 1'b0;
            hc_readdata <= '0;
            dc_readdata <= '0;
            bus_cs_n    <= 1'b1;
            bus_rd_n    <= 1'b1;
            bus_wr_n    <= 1'b1;
            bus_a       <= '0;
            bus_dout    <= '0;
            bus_doe     <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            wr    <= nxt_wr;
            if (go) begin
                gnt_dc  <= pick_dc;
                last_dc <= pick_dc;
                bus_a   <= pick_dc ? dc_address[17:1] : hc_address[17:1];
                if (sel_wr) bus_dout <= pick_dc ? dc_writedata : hc_writedata;
            end
            ack_hc <= done & ~gnt_dc;
            ack_dc <= done & gnt_dc;
            if (last_strobe & ~wr & ~gnt_dc) hc_readdata <= bus_din;
            if (last_strobe & ~wr & gnt_dc) dc_readdata <= bus_din;
            bus_cs_n <= ~on_bus;
            bus_rd_n <= ~((nxt_state == STROBE) & ~nxt_wr);
            bus_wr_n <= ~((nxt_state == STROBE) & nxt_wr);
            bus_doe  <= on_bus & nxt_wr;
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(~bus_rd_n & ~bus_wr_n));
    assert property (@(posedge clk) disable iff (reset) bus_cs_n |-> ~bus_doe);
endmodule

// File: tb/tb_isp1761_bus_sequencer.sv
// tb_isp1761_bus_sequencer: randomized two-master traffic scored against a timeline model,
// plus directed reset-abort and zero-hold/zero-recovery checks.
module tb_isp1761_bus_sequencer;
    localparam int S = 1, P = 2, H = 1, R = 1;
    localparam int NTX = 40;
    typedef struct packed {
        logic        wr;
        logic [16:0] a;
        logic [31:0] d;
    } txn_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        rd_r [2];
    logic        wr_r [2];
    logic [17:0] addr_r [2];
    logic [31:0] wdata_r [2];
    logic [31:0] bus_din = '0;
    logic [31:0] hc_rdata, dc_rdata, bus_dout;
    logic        hc_wait, dc_wait, cs_n, rd_n, wr_n, doe;
    logic [16:0] bus_a;
    bit          go = 0, done2 = 0;
    bit          done [2];
    txn_t        exp_q [2][$];
    int          checks = 0, fails = 0;

    logic        b_reset = 1'b0, b_hc_read = 1'b0, b_zero = 1'b0;
    logic [17:0] b_hc_addr = '0, b_zaddr = '0;
    logic [31:0] b_din = '0, b_zdata = '0;
    logic [31:0] b_hc_rdata, b_dc_rdata, b_dout;
    logic        b_hc_wait, b_dc_wait, b_cs_n, b_rd_n, b_wr_n, b_doe;
    logic [16:0] b_a;

    always #5 clk = ~clk;

    isp1761_bus_sequencer u_dut (
        .clk(clk), .reset(reset),
        .hc_read(rd_r[0]), .hc_write(wr_r[0]), .hc_address(addr_r[0]), .hc_writedata(wdata_r[0]),
        .hc_readdata(hc_rdata), .hc_waitrequest(hc_wait),
        .dc_read(rd_r[1]), .dc_write(wr_r[1]), .dc_address(addr_r[1]), .dc_writedata(wdata_r[1]),
        .dc_readdata(dc_rdata), .dc_waitrequest(dc_wait),
        .bus_cs_n(cs_n), .bus_rd_n(rd_n), .bus_wr_n(wr_n), .bus_a(bus_a),
        .bus_dout(bus_dout), .bus_doe(doe), .bus_din(bus_din)
    );

    isp1761_bus_sequencer #(.T_HOLD(0), .T_RECOVER(0)) u_dut2 (
        .clk(clk), .reset(b_reset),
        .hc_read(b_hc_read), .hc_write(b_zero), .hc_address(b_hc_addr), .hc_writedata(b_zdata),
        .hc_readdata(b_hc_rdata), .hc_waitrequest(b_hc_wait),
        .dc_read(b_zero), .dc_write(b_zero), .dc_address(b_zaddr), .dc_writedata(b_zdata),
        .dc_readdata(b_dc_rdata), .dc_waitrequest(b_dc_wait),
        .bus_cs_n(b_cs_n), .bus_rd_n(b_rd_n), .bus_wr_n(b_wr_n), .bus_a(b_a),
        .bus_dout(b_dout), .bus_doe(b_doe), .bus_din(b_din)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic wait_of(input int m);
        return (m == 0) ? hc_wait : dc_wait;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? hc_rdata : dc_rdata;
    endfunction

    // One Avalon master: random gaps, read/write/both, holds each request until accepted.
    task automatic drive(input int m);
        txn_t t;
        int   k;
        bit   ok;
        wait (go);
        #1;
        for (int n = 0; n < NTX; n++) begin
            repeat ((n == 0) ? 0 : $urandom_range(0, 3)) begin
                @(posedge clk);
                #2;
            end
            k          = $urandom_range(0, 9);
            addr_r[m]  = 18'($urandom);
            wdata_r[m] = $urandom;
            rd_r[m]    = (k < 5) || (k == 9);
            wr_r[m]    = (k >= 5);
            t.wr = wr_r[m];
            t.a  = addr_r[m][17:1];
            t.d  = wdata_r[m];
            exp_q[m].push_back(t);
            ok = 0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(negedge clk);
                ok = !wait_of(m);
            end
            chk("req_accepted", 32'(ok), 1);
            if (!ok) break;
            @(posedge clk);
            #2;
            rd_r[m] = 0;
            wr_r[m] = 0;
        end
        done[m] = 1;
    endtask

    initial drive(0);
    initial drive(1);

    initial forever begin
        @(posedge clk);
        #2 bus_din = $urandom;
    end

    // Timeline model: grant at cycle g, CS low g+1..g+S+P+H, strobe g+1+S..g+S+P,
    // ack at g+1+S+P+H, next grant allowed from ack cycle + R.
    initial begin : monitor
        int          cyc = 0, tg = 0, free_at = 0, cm = 0;
        bit          act = 0, last = 1, e0, e1, pick, cs_e, st_e;
        bit          ack_e [2];
        txn_t        cur = '0;
        logic [31:0] rd_exp [2];
        rd_exp[0] = '0;
        rd_exp[1] = '0;
        wait (go);
        forever begin
            @(negedge clk);
            cs_e = act && cyc >= tg + 1 && cyc <= tg + S + P + H;
            st_e = act && cyc >= tg + 1 + S && cyc <= tg + S + P;
            for (int m = 0; m < 2; m++) ack_e[m] = act && cm == m && cyc == tg + 1 + S + P + H;
            chk("bus_cs_n", 32'(cs_n), 32'(!cs_e));
            chk("bus_rd_n", 32'(rd_n), 32'(!(st_e && !cur.wr)));
            chk("bus_wr_n", 32'(wr_n), 32'(!(st_e && cur.wr)));
            chk("bus_doe", 32'(doe), 32'(cs_e && cur.wr));
            if (cs_e) chk("bus_a", 32'(bus_a), 32'(cur.a));
            if (cs_e && cur.wr) chk("bus_dout", bus_dout, cur.d);
            for (int m = 0; m < 2; m++) begin
                chk(m ? "dc_waitrequest" : "hc_waitrequest", 32'(wait_of(m)),
                    32'((rd_r[m] | wr_r[m]) & ~ack_e[m]));
                chk(m ? "dc_readdata" : "hc_readdata", rdata_of(m), rd_exp[m]);
            end
            if (st_e && !cur.wr && cyc == tg + S + P) rd_exp[cm] = bus_din;
            if (cyc >= free_at) begin
                e0 = (rd_r[0] | wr_r[0]) && !ack_e[0];
                e1 = (rd_r[1] | wr_r[1]) && !ack_e[1];
                if (e0 || e1) begin
                    pick = e1 && (!e0 || !last);
                    last = pick;
                    cm   = int'(pick);
                    chk("grant_has_request", 32'(exp_q[cm].size() > 0), 1);
                    if (exp_q[cm].size() > 0) cur = exp_q[cm].pop_front();
                    tg      = cyc;
                    act     = 1;
                    free_at = cyc + 1 + S + P + H + R;
                end
            end
            cyc++;
        end
    end

    // Zero hold / zero recovery: back-to-back reads from one master.
    initial begin
        #1 b_reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 b_reset = 1'b0;
        @(posedge clk);
        #2;
        b_hc_read = 1'b1;
        b_hc_addr = 18'h00300;
        b_din     = 32'hA5A50001;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("t4_cs_n", 32'(b_cs_n), (n inside {1, 2, 3, 6, 7, 8}) ? 0 : 1);
            chk("t4_rd_n", 32'(b_rd_n), (n inside {2, 3, 7, 8}) ? 0 : 1);
            chk("t4_wr_n", 32'(b_wr_n), 1);
            chk("t4_doe", 32'(b_doe), 0);
            chk("t4_hc_waitrequest", 32'(b_hc_wait), (n == 4 || n == 9) ? 0 : 1);
            chk("t4_dc_waitrequest", 32'(b_dc_wait), 0);
            if (n == 1) chk("t4_bus_a", 32'(b_a), 32'h180);
            if (n == 4) chk("t4_readdata1", b_hc_rdata, 32'hA5A50001);
            if (n == 9) chk("t4_readdata2", b_hc_rdata, 32'h5A5A0002);
            @(posedge clk);
            #2;
            if (n == 4) b_din = 32'h5A5A0002;
            if (n == 9) b_hc_read = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            chk("t4_idle_cs_n", 32'(b_cs_n), 1);
        end
        chk("t4_dc_readdata", b_dc_rdata, 0);
        chk("t4_bus_dout", b_dout, 0);
        done2 = 1;
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            rd_r[m] = 0; wr_r[m] = 0; addr_r[m] = '0; wdata_r[m] = '0; done[m] = 0;
        end
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 1);
        chk("rst_rd_n", 32'(rd_n), 1);
        chk("rst_wr_n", 32'(wr_n), 1);
        chk("rst_doe", 32'(doe), 0);
        chk("rst_bus_a", 32'(bus_a), 0);
        chk("rst_bus_dout", bus_dout, 0);
        chk("rst_hc_readdata", hc_rdata, 0);
        chk("rst_dc_readdata", dc_rdata, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #2;
        wr_r[1]    = 1'b1;
        addr_r[1]  = 18'h0020C;
        wdata_r[1] = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t5_strobe_wr_n", 32'(wr_n), 0);
        chk("t5_strobe_cs_n", 32'(cs_n), 0);
        chk("t5_strobe_doe", 32'(doe), 1);
        chk("t5_strobe_bus_a", 32'(bus_a), 32'h106);
        chk("t5_strobe_dout", bus_dout, 32'h12345678);
        #2 reset = 1'b1;
        #1;
        chk("t5_abort_cs_n", 32'(cs_n), 1);
        chk("t5_abort_wr_n", 32'(wr_n), 1);
        chk("t5_abort_doe", 32'(doe), 0);
        chk("t5_abort_dc_waitrequest", 32'(dc_wait), 1);
        wr_r[1] = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 go = 1;
        for (int t = 0; t < 30000 && !(done[0] && done[1] && done2); t++) @(posedge clk);
        chk("all_done", 32'(done[0] && done[1] && done2), 1);
        repeat (12) @(posedge clk);
        chk("hc_queue_empty", 32'(exp_q[0].size()), 0);
        chk("dc_queue_empty", 32'(exp_q[1].size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
